fft_stage_sequencer_rtl: RTL and testbench
==========================================

// Module: fft_stage_sequencer_rtl
// PURPOSE
//  Drives an in-place radix-2 DIT FFT through one fft_block_rtl butterfly: reads sample pairs and
//  twiddles, presents first/second/phase_factor, captures first_out/second_out BFLY_LATENCY cycles later,
//  writes results back to the same addresses. Sits between sample RAM/twiddle ROM and the butterfly.
//  RAM holds input in bit-reversed order.
// PARAMETERS
//  N_POINTS      64  transform size; power of two, >= 4
//  BFLY_LATENCY  5   cycles from bf_* inputs to bf_*_out valid (fft_block_rtl with registered comp_mult)
//  LOG2N         $clog2(N_POINTS)  derived; do not override
// PORTS
//  clk           in   1        single clock, rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  start         in   1        pulse; starts a transform when idle
//  busy          out  1        high from first issue cycle to final write cycle
//  done          out  1        1-cycle pulse after final write
//  stage         out  LOG2N    current stage index 0..LOG2N-1
//  rd_en         out  1        RAM read strobe; data returned 1 cycle later
//  rd_addr_a/_b  out  LOG2N    addresses of upper/lower butterfly operands
//  rd_data_a/_b  in   complex_t RAM read data
//  tw_addr       out  LOG2N-1  twiddle ROM index (W_N^tw_addr); data 1 cycle later
//  tw_data       in   complex_t twiddle value
//  bf_first/bf_second/bf_phase  out complex_t  to butterfly first/second/phase_factor
//  bf_first_out/bf_second_out   in  complex_t  from butterfly
//  wr_en         out  1        RAM write strobe (both ports)
//  wr_addr_a/_b  out  LOG2N    write addresses
//  wr_data_a/_b  out  complex_t = bf_first_out / bf_second_out
// BEHAVIOUR
//  - Reset (async assert, sync release): FSM=IDLE, counters, stage and valid pipe cleared; every output 0.
//  - FSM: IDLE -start-> ISSUE; ISSUE (N/2 cycles) -> DRAIN (1+BFLY_LATENCY cycles);
//    DRAIN -> ISSUE with stage+1, or -> IDLE with done=1 after last stage.
//  - start while busy ignored; start and done same cycle: done wins, new start ignored.
//  - ISSUE pair k (0..N/2-1), stage s, half=2^s: j=k&(half-1); a=((k>>s)<<(s+1))+j; b=a+half;
//    tw_addr=j<<(LOG2N-1-s); rd_en=1.
//  - Timing per pair issued cycle t: rd_data/tw_data at t+1; bf_* driven combinationally from them at t+1,
//    forced to 0 when the t+1 valid bit is 0; wr_en/wr_addr/wr_data at t+1+BFLY_LATENCY.
//  - Addresses carried by a (1+BFLY_LATENCY)-deep shift register with valid bit; wr_en = valid tap.
//  - DRAIN guarantees last write of stage s lands before first read of stage s+1 (no RAW hazard).
//  - Per transform: busy high LOG2N*(N/2+1+BFLY_LATENCY) cycles; busy rises cycle after start accepted.
//  - Counters wrap never: k stops at N/2-1, stage at LOG2N-1; arithmetic unsigned, widths exact.
//  - reset_n low mid-transform: immediate return to IDLE, in-flight writes discarded (wr_en=0).
//  - Butterfly sync reset is driven externally from ~reset_n; not owned by this block.
// STRUCTURE
//  - fft_package: word_t, complex_t (existing); add bf_latency_c=5 constant for shared use.
//  - Sub-module fft_addr_gen_rtl: stage/k counters -> rd_addr_a/_b, tw_addr, last_pair, last_stage.
//  - Top: FSM, address/valid delay line, bf_* gating, write port.
// TESTING (N_POINTS=8, BFLY_LATENCY=5)
//  - reset_n=0 mid-run -> all outputs 0 same cycle, busy=0; after release no wr_en until next start.
//  - start -> stage0 pairs (0,1)(2,3)(4,5)(6,7) tw 0; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2;
//    stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3.
//  - every wr_en exactly 6 cycles after its rd_en with identical addresses; busy high 30 cycles; done 1 cycle.
//  - with RAM model + fft_block_rtl: impulse x[0]=1.0 -> all 8 bins 1.0+0j within 1 LSB.
//  - constant x[n]=0.0625 -> X[0]=0.5, X[1..7]=0 within 1 LSB.
//  - start pulsed at busy cycles 3 and 29 -> ignored; run completes in 30 cycles; next start restarts stage 0.

Source files
------------

// File: rtl/fft_stage_sequencer_rtl_pkg.sv
// ----------------------------------------------------------------------------
// fft_package
//   Shared types for the FFT datapath: fixed-point word, packed complex
//   sample, the default butterfly pipeline latency and the state encoding of
//   the stage sequencer.
//   Samples are signed Q2.14 (1.0 == 16384).
// ----------------------------------------------------------------------------
package fft_package;

    typedef logic signed [15:0] word_t;

    typedef struct packed {
        word_t re;
        word_t im;
    } complex_t;

    // fft_block_rtl with registered comp_mult: bf_* in -> bf_*_out valid.
    localparam int unsigned bf_latency_c = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/fft_stage_sequencer_rtl_addr_gen.sv
// ----------------------------------------------------------------------------
// fft_addr_gen_rtl
//   Stage / pair counters of an in-place radix-2 DIT FFT and the operand and
//   twiddle addresses derived from them.
//   Ports:
//     clk, reset_n      clock, asynchronous active-low reset
//     clear             hold both counters at zero
//     k_step            advance pair index k (never wraps past N/2-1)
//     stage_step        advance stage, restart k at 0
//     stage             current stage index
//     addr_a / addr_b   upper / lower operand addresses of pair k
//     tw_addr           twiddle index W_N^tw_addr for pair k
//     last_pair         k == N/2-1
//     last_stage        stage == LOG2N-1
// ----------------------------------------------------------------------------
module fft_addr_gen_rtl
    import fft_package::*;
#(
    parameter int unsigned N_POINTS = 64,
    parameter int unsigned LOG2N    = $clog2(N_POINTS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             k_step,
    input  logic             stage_step,
    output logic [LOG2N-1:0] stage,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             last_pair,
    output logic             last_stage
);

    localparam logic [LOG2N-2:0] k_last       = (LOG2N-1)'(N_POINTS/2 - 1);
    localparam logic [LOG2N-1:0] stage_last   = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] tw_shift_top = LOG2N'(LOG2N - 1);

    logic [LOG2N-2:0] k;
    logic [LOG2N-1:0] k_wide;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] low_mask;
    logic [LOG2N-1:0] j;
    logic [LOG2N-1:0] tw_wide;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k     <= '0;
            stage <= '0;
        end else if (clear) begin
            k     <= '0;
            stage <= '0;
        end else if (stage_step) begin
            k     <= '0;
            stage <= stage + 1'b1;
        end else if (k_step) begin
            k     <= k + 1'b1;
        end
    end

    // a = ((k >> s) << (s+1)) + j is computed as: clear the low s bits of k,
    // shift left once, then OR j back in (bit s of a is always zero, so
    // b = a + half is also an OR).
    always_comb begin
        k_wide      = {1'b0, k};
        half        = '0;
        half[stage] = 1'b1;
        low_mask    = half - 1'b1;
        j           = k_wide & low_mask;
        addr_a      = ((k_wide & ~low_mask) << 1) | j;
        addr_b      = addr_a | half;
        tw_wide     = j << (tw_shift_top - stage);
        tw_addr     = tw_wide[LOG2N-2:0];
    end

    assign last_pair  = (k == k_last);
    assign last_stage = (stage == stage_last);

endmodule

// File: rtl/fft_stage_sequencer_rtl.sv
// ----------------------------------------------------------------------------
// fft_stage_sequencer_rtl
//   Runs an in-place radix-2 DIT FFT (bit-reversed input in RAM) through a
//   single pipelined butterfly. Each stage issues N/2 operand-pair reads, then
//   drains 1+BFLY_LATENCY cycles so the last write lands before the next
//   stage's first read.
//   Ports:
//     clk, reset_n                    clock, asynchronous active-low reset
//     start / busy / done             transform control and status
//     stage                           current stage index
//     rd_en, rd_addr_a/_b             RAM read (data returned next cycle)
//     rd_data_a/_b                    RAM read data
//     tw_addr / tw_data               twiddle ROM index and data (next cycle)
//     bf_first/_second/_phase         butterfly operands (zero when idle)
//     bf_first_out/_second_out        butterfly results
//     wr_en, wr_addr_a/_b, wr_data_a/_b  RAM write-back of the results
// ----------------------------------------------------------------------------
module fft_stage_sequencer_rtl
    import fft_package::*;
#(
    parameter int unsigned N_POINTS     = 64,
    parameter int unsigned BFLY_LATENCY = bf_latency_c,
    parameter int unsigned LOG2N        = $clog2(N_POINTS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG2N-1:0] stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    input  complex_t         rd_data_a,
    input  complex_t         rd_data_b,
    output logic [LOG2N-2:0] tw_addr,
    input  complex_t         tw_data,
    output complex_t         bf_first,
    output complex_t         bf_second,
    output complex_t         bf_phase,
    input  complex_t         bf_first_out,
    input  complex_t         bf_second_out,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output complex_t         wr_data_a,
    output complex_t         wr_data_b
);

    localparam int unsigned DW = $clog2(BFLY_LATENCY + 2);
    localparam logic [DW-1:0] drain_end = DW'(BFLY_LATENCY);

    seq_state_t state;
    logic [DW-1:0] drain_cnt;

    logic             clear;
    logic             k_step;
    logic             stage_step;
    logic             drain_last;
    logic             last_pair;
    logic             last_stage;
    logic [LOG2N-1:0] gen_a;
    logic [LOG2N-1:0] gen_b;
    logic [LOG2N-2:0] gen_tw;

    // Address/valid delay line: tap 0 lines up with the returned read data,
    // tap BFLY_LATENCY with the butterfly result.
    logic             pipe_valid [0:BFLY_LATENCY];
    logic [LOG2N-1:0] pipe_a     [0:BFLY_LATENCY];
    logic [LOG2N-1:0] pipe_b     [0:BFLY_LATENCY];

    assign drain_last = (state == ST_DRAIN) && (drain_cnt == drain_end);
    assign k_step     = (state == ST_ISSUE) && !last_pair;
    assign stage_step = drain_last && !last_stage;
    // Counters return to zero on the final drain cycle so stage reads 0
    // from the done cycle onward.
    assign clear      = (state == ST_IDLE) || (drain_last && last_stage);

    fft_addr_gen_rtl #(
        .N_POINTS (N_POINTS),
        .LOG2N    (LOG2N)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .k_step     (k_step),
        .stage_step (stage_step),
        .stage      (stage),
        .addr_a     (gen_a),
        .addr_b     (gen_b),
        .tw_addr    (gen_tw),
        .last_pair  (last_pair),
        .last_stage (last_stage)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        state <= ST_ISSUE;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (last_pair) begin
                        state     <= ST_DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        if (last_stage) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                            rd_en <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr_a = rd_en ? gen_a  : '0;
    assign rd_addr_b = rd_en ? gen_b  : '0;
    assign tw_addr   = rd_en ? gen_tw : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i <= BFLY_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_a[i]     <= '0;
                pipe_b[i]     <= '0;
            end
        end else begin
            pipe_valid[0] <= rd_en;
            pipe_a[0]     <= rd_addr_a;
            pipe_b[0]     <= rd_addr_b;
            for (int unsigned i = 1; i <= BFLY_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_a[i]     <= pipe_a[i-1];
                pipe_b[i]     <= pipe_b[i-1];
            end
        end
    end

    assign bf_first  = pipe_valid[0] ? rd_data_a : '0;
    assign bf_second = pipe_valid[0] ? rd_data_b : '0;
    assign bf_phase  = pipe_valid[0] ? tw_data   : '0;

    assign wr_en     = pipe_valid[BFLY_LATENCY];
    assign wr_addr_a = pipe_a[BFLY_LATENCY];
    assign wr_addr_b = pipe_b[BFLY_LATENCY];
    assign wr_data_a = wr_en ? bf_first_out  : '0;
    assign wr_data_b = wr_en ? bf_second_out : '0;

endmodule

// File: tb/tb_fft_stage_sequencer_rtl.sv
module tb_fft_stage_sequencer_rtl;
    import fft_package::*;

    localparam int unsigned N  = 8;
    localparam int unsigned L  = 5;
    localparam int unsigned LG = 3;
    localparam int RUN = 30;   // LOG2N*(N/2+1+L)
    localparam int PER = 10;   // cycles per stage

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, rd_en, wr_en;
    logic [LG-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LG-2:0] tw_addr;
    complex_t rd_data_a = '0, rd_data_b = '0, tw_data = '0;
    complex_t bf_first, bf_second, bf_phase, bf_first_out, bf_second_out;
    complex_t wr_data_a, wr_data_b;

    always #5 clk = ~clk;

    fft_stage_sequencer_rtl #(.N_POINTS(N), .BFLY_LATENCY(L)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .tw_addr(tw_addr), .tw_data(tw_data),
        .bf_first(bf_first), .bf_second(bf_second), .bf_phase(bf_phase),
        .bf_first_out(bf_first_out), .bf_second_out(bf_second_out),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input int act, input int exp);
        total++;
        if (act - exp > 1 || exp - act > 1) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (+-1)", name, act, exp);
        end
    endtask

    // ---------------- RAM, twiddle ROM and butterfly models ----------------
    complex_t mem[0:N-1];
    complex_t init_mem[0:N-1];
    complex_t rom[0:N/2-1];
    logic load = 1'b0;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
        end else if (wr_en) begin
            mem[wr_addr_a] <= wr_data_a;
            mem[wr_addr_b] <= wr_data_b;
        end
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
        tw_data <= rom[tw_addr];
    end

    function automatic complex_t cmul(input complex_t x, input complex_t w);
        complex_t r;
        int pr, pi;
        pr = ($signed(x.re) * $signed(w.re) - $signed(x.im) * $signed(w.im)) >>> 14;
        pi = ($signed(x.re) * $signed(w.im) + $signed(x.im) * $signed(w.re)) >>> 14;
        r.re = word_t'(pr);
        r.im = word_t'(pi);
        return r;
    endfunction

    complex_t bp1[0:L-1];
    complex_t bp2[0:L-1];
    always @(posedge clk) begin
        complex_t t;
        t = cmul(bf_second, bf_phase);
        bp1[0].re <= bf_first.re + t.re;
        bp1[0].im <= bf_first.im + t.im;
        bp2[0].re <= bf_first.re - t.re;
        bp2[0].im <= bf_first.im - t.im;
        for (int i = 1; i < L; i++) begin
            bp1[i] <= bp1[i-1];
            bp2[i] <= bp2[i-1];
        end
    end
    assign bf_first_out  = bp1[L-1];
    assign bf_second_out = bp2[L-1];

    // ---------------- reference schedule (group/offset enumeration) --------
    int exp_a[12], exp_b[12], exp_tw[12];
    initial begin
        int idx;
        idx = 0;
        for (int s = 0; s < LG; s++) begin
            int half;
            half = 1 << s;
            for (int g = 0; g < N / (2 * half); g++)
                for (int j = 0; j < half; j++) begin
                    exp_a[idx]  = g * 2 * half + j;
                    exp_b[idx]  = g * 2 * half + j + half;
                    exp_tw[idx] = j * (N / (2 * half));
                    idx++;
                end
        end
    end

    // pos: -1 idle, 0..RUN-1 busy cycle index, RUN = done cycle
    int pos = -1;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 pos <= -1;
        else if (pos >= 0 && pos < RUN) pos <= pos + 1;
        else if (pos == -1 && start)  pos <= 0;
        else                          pos <= -1;
    end

    always @(negedge clk) begin
        bit e_busy, e_rd, e_wr, e_bf;
        int ri, wi, w, v;
        e_busy = (pos >= 0 && pos < RUN);
        e_rd   = e_busy && (pos % PER) < N/2;
        ri     = e_rd ? (pos / PER) * (N/2) + pos % PER : 0;
        w      = pos - (1 + L);
        e_wr   = (w >= 0 && w < RUN && (w % PER) < N/2);
        wi     = e_wr ? (w / PER) * (N/2) + w % PER : 0;
        v      = pos - 1;
        e_bf   = (v >= 0 && v < RUN && (v % PER) < N/2);
        chk("busy",  64'(busy),  64'(e_busy));
        chk("done",  64'(done),  64'(pos == RUN));
        chk("stage", 64'(stage), e_busy ? 64'(pos / PER) : 64'd0);
        chk("rd_en", 64'(rd_en), 64'(e_rd));
        chk("rd_addr_a", 64'(rd_addr_a), e_rd ? 64'(exp_a[ri])  : 64'd0);
        chk("rd_addr_b", 64'(rd_addr_b), e_rd ? 64'(exp_b[ri])  : 64'd0);
        chk("tw_addr",   64'(tw_addr),   e_rd ? 64'(exp_tw[ri]) : 64'd0);
        chk("wr_en",     64'(wr_en),     64'(e_wr));
        chk("wr_addr_a", 64'(wr_addr_a), e_wr ? 64'(exp_a[wi]) : 64'd0);
        chk("wr_addr_b", 64'(wr_addr_b), e_wr ? 64'(exp_b[wi]) : 64'd0);
        chk("bf_first",  64'(bf_first),  e_bf ? 64'(rd_data_a) : 64'd0);
        chk("bf_second", 64'(bf_second), e_bf ? 64'(rd_data_b) : 64'd0);
        chk("bf_phase",  64'(bf_phase),  e_bf ? 64'(tw_data)   : 64'd0);
        chk("wr_data_a", 64'(wr_data_a), e_wr ? 64'(bf_first_out)  : 64'd0);
        chk("wr_data_b", 64'(wr_data_b), e_wr ? 64'(bf_second_out) : 64'd0);
    end

    // ---------------- read/write event log for literal pinning -------------
    int cyc = 0, nrd = 0, nwr = 0;
    int rd_cyc[16], wr_cyc[16];
    int lg_a[16], lg_b[16], lg_tw[16], lw_a[16], lw_b[16];
    logic log_clr = 1'b0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (log_clr) begin
            nrd = 0;
            nwr = 0;
        end else begin
            if (rd_en && nrd < 16) begin
                rd_cyc[nrd] = cyc; lg_a[nrd] = int'(rd_addr_a);
                lg_b[nrd] = int'(rd_addr_b); lg_tw[nrd] = int'(tw_addr);
                nrd = nrd + 1;
            end
            if (wr_en && nwr < 16) begin
                wr_cyc[nwr] = cyc; lw_a[nwr] = int'(wr_addr_a); lw_b[nwr] = int'(wr_addr_b);
                nwr = nwr + 1;
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    int lit_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic load_ram(input int re0, input int re_rest);
        for (int i = 0; i < N; i++) begin
            init_mem[i].re = word_t'(i == 0 ? re0 : re_rest);
            init_mem[i].im = '0;
        end
        load = 1'b1;
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    // Called at posedge+2. Returns the number of busy cycles observed.
    task automatic run_transform(input bit extra_starts, output int busy_cnt);
        busy_cnt = 0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        while (busy === 1'b1 && busy_cnt < 100) begin
            start = extra_starts && (busy_cnt == 3 || busy_cnt == 29);
            busy_cnt++;
            @(posedge clk); #2;
        end
        start = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        start = extra_starts;   // start in the done cycle must be dropped
        @(posedge clk); #2;
        start = 1'b0;
        chk("done_width", 64'(done), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("busy_cycles", 64'(busy_cnt), 64'(RUN));
    endtask

    initial begin
        int bc;
        int wcount;
        rom[0].re = 16'sd16384;  rom[0].im = 16'sd0;
        rom[1].re = 16'sd11585;  rom[1].im = -16'sd11585;
        rom[2].re = 16'sd0;      rom[2].im = -16'sd16384;
        rom[3].re = -16'sd11585; rom[3].im = -16'sd11585;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_addr_b", 64'(rd_addr_b), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #2;

        // Impulse: all bins 1.0 + 0j, with literal schedule pinning.
        load_ram(16384, 0);
        log_clr = 1'b1; @(posedge clk); #2; log_clr = 1'b0;
        run_transform(1'b0, bc);
        chk("n_reads", 64'(nrd), 64'd12);
        chk("n_writes", 64'(nwr), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < nrd && i < nwr) begin
                chk("lit_rd_a", 64'(lg_a[i]), 64'(lit_a[i]));
                chk("lit_rd_b", 64'(lg_b[i]), 64'(lit_b[i]));
                chk("lit_tw", 64'(lg_tw[i]), 64'(lit_tw[i]));
                chk("lit_wr_a", 64'(lw_a[i]), 64'(lit_a[i]));
                chk("lit_wr_b", 64'(lw_b[i]), 64'(lit_b[i]));
                chk("wr_lag", 64'(wr_cyc[i] - rd_cyc[i]), 64'd6);
            end
        end
        for (int i = 0; i < N; i++) begin
            chk_near("impulse_re", int'(mem[i].re), 16384);
            chk_near("impulse_im", int'(mem[i].im), 0);
        end

        // Constant 0.0625, with ignored starts at busy cycles 3, 29 and done.
        load_ram(1024, 1024);
        run_transform(1'b1, bc);
        for (int i = 0; i < N; i++) begin
            chk_near("const_re", int'(mem[i].re), i == 0 ? 8192 : 0);
            chk_near("const_im", int'(mem[i].im), 0);
        end

        // Reset in the middle of stage 1 with writes in flight.
        start = 1'b1; @(posedge clk); #2; start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_stage", 64'(stage), 64'd0);
        chk("abort_rd", 64'({rd_en, rd_addr_a, rd_addr_b, tw_addr}), 64'd0);
        chk("abort_wr", 64'({wr_en, wr_addr_a, wr_addr_b}), 64'd0);
        chk("abort_wdata", {wr_data_a, wr_data_b}, 64'd0);
        chk("abort_bf", 64'({bf_first, bf_second}), 64'd0);
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        wcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_en) wcount++;
        end
        chk("no_wr_after_abort", 64'(wcount), 64'd0);
        @(posedge clk); #2;

        // Restart after abort begins again at stage 0 with pair (0,1).
        log_clr = 1'b1; @(posedge clk); #2; log_clr = 1'b0;
        run_transform(1'b0, bc);
        chk("restart_a", 64'(lg_a[0]), 64'd0);
        chk("restart_b", 64'(lg_b[0]), 64'd1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
